// File: rtl/button_event_arbiter.sv
// Per-button press/long/repeat/release event generator with one pending slot per
// button, round-robin arbitrated onto a single registered valid/ready event stream.
module button_event_arbiter #(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned IDX_W         = 2,
    parameter int unsigned HOLD_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_db,
    output logic             evt_valid,
    output logic [IDX_W-1:0] evt_btn,
    output logic [1:0]       evt_type,
    input  logic             evt_ready,
    output logic [N_BTN-1:0] overrun
);

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [1:0] EVT_PRESS   = 2'b00;
    localparam logic [1:0] EVT_LONG    = 2'b01;
    localparam logic [1:0] EVT_REPEAT  = 2'b10;
    localparam logic [1:0] EVT_RELEASE = 2'b11;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_IDLE     = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_HELD     = 2'd3
    } btn_state_t;

    logic [N_BTN-1:0] btn_q;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] fall;

    btn_state_t       state     [N_BTN];
    btn_state_t       state_nxt [N_BTN];
    logic [CNT_W-1:0] cnt       [N_BTN];
    logic [CNT_W-1:0] cnt_nxt   [N_BTN];

    logic [N_BTN-1:0] emit;
    logic [1:0]       emit_type [N_BTN];

    logic [N_BTN-1:0] slot_v;
    logic [1:0]       slot_t [N_BTN];

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic             load;
    logic [N_BTN-1:0] grant_hit;

    assign rise = btn_db & ~btn_q;
    assign fall = ~btn_db & btn_q;

    // Button FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(N_BTN); i++) begin
                state[i] <= ST_DISARMED;
                cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_BTN); i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
        end
    end

    // Button FSM next state; a fall always wins over a same-cycle LONG/REPEAT
    always_comb begin
        for (int i = 0; i < int'(N_BTN); i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            case (state[i])
                ST_DISARMED: begin
                    if (!btn_db[i]) state_nxt[i] = ST_IDLE;
                end
                ST_IDLE: begin
                    if (rise[i]) begin
                        state_nxt[i] = ST_PRESSED;
                        cnt_nxt[i]   = '0;
                    end
                end
                ST_PRESSED: begin
                    if (fall[i]) begin
                        state_nxt[i] = ST_IDLE;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == HOLD_LAST) begin
                        state_nxt[i] = ST_HELD;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] != CNT_MAX) begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (fall[i]) begin
                        state_nxt[i] = ST_IDLE;
                        cnt_nxt[i]   = '0;
                    end else if (cnt[i] == REP_LAST) begin
                        cnt_nxt[i] = '0;
                    end else if (cnt[i] != CNT_MAX) begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                default: state_nxt[i] = ST_DISARMED;
            endcase
        end
    end

    // Button FSM event outputs
    always_comb begin
        emit = '0;
        for (int i = 0; i < int'(N_BTN); i++) begin
            emit_type[i] = EVT_PRESS;
            case (state[i])
                ST_IDLE: begin
                    if (rise[i]) begin
                        emit[i]      = 1'b1;
                        emit_type[i] = EVT_PRESS;
                    end
                end
                ST_PRESSED: begin
                    if (fall[i]) begin
                        emit[i]      = 1'b1;
                        emit_type[i] = EVT_RELEASE;
                    end else if (cnt[i] == HOLD_LAST) begin
                        emit[i]      = 1'b1;
                        emit_type[i] = EVT_LONG;
                    end
                end
                ST_HELD: begin
                    if (fall[i]) begin
                        emit[i]      = 1'b1;
                        emit_type[i] = EVT_RELEASE;
                    end else if (cnt[i] == REP_LAST) begin
                        emit[i]      = 1'b1;
                        emit_type[i] = EVT_REPEAT;
                    end
                end
                default: ;
            endcase
        end
    end

    // Round-robin search upward from rr_ptr with wrap
    always_comb begin
        int idx;
        load        = ~evt_valid | evt_ready;
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_hit   = '0;
        idx         = 0;
        for (int k = 0; k < int'(N_BTN); k++) begin
            idx = (int'(rr_ptr) + k) % int'(N_BTN);
            if (!grant_valid && slot_v[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_W'(idx);
            end
        end
        if (load && grant_valid) grant_hit[grant_idx] = 1'b1;
    end

    // Pending slots, overrun pulses and the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q     <= '0;
            slot_v    <= '0;
            overrun   <= '0;
            evt_valid <= 1'b0;
            evt_btn   <= '0;
            evt_type  <= '0;
            rr_ptr    <= '0;
            for (int i = 0; i < int'(N_BTN); i++) slot_t[i] <= '0;
        end else begin
            btn_q <= btn_db;
            for (int i = 0; i < int'(N_BTN); i++) begin
                overrun[i] <= emit[i] & slot_v[i] & ~grant_hit[i];
                if (emit[i]) begin
                    slot_v[i] <= 1'b1;
                    slot_t[i] <= emit_type[i];
                end else if (grant_hit[i]) begin
                    slot_v[i] <= 1'b0;
                end
            end
            if (load) begin
                evt_valid <= grant_valid;
                if (grant_valid) begin
                    evt_btn  <= grant_idx;
                    evt_type <= slot_t[grant_idx];
                    rr_ptr   <= (grant_idx == IDX_W'(N_BTN - 1)) ? '0 : grant_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule
